// File: rtl/flash_copy_dma_pkg.sv
// Shared types and constants for the flash-to-program-memory copy engine.
package flash_copy_dma_pkg;

    // Copy sequencer states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } dma_state_e;

    // MMIO register indices
    localparam logic [1:0] RegSrc  = 2'd0;
    localparam logic [1:0] RegDst  = 2'd1;
    localparam logic [1:0] RegLen  = 2'd2;
    localparam logic [1:0] RegCtrl = 2'd3;

    // CTRL write bits
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlAbortBit = 1;

    // STATUS read bits; remaining word count sits in [31:16]
    localparam int unsigned StatBusyBit = 0;
    localparam int unsigned StatDoneBit = 1;
    localparam int unsigned StatErrBit  = 2;

    function automatic logic [31:0] status_word(input logic        busy,
                                                input logic        done,
                                                input logic        err,
                                                input logic [15:0] rem);
        logic [31:0] w;
        w              = '0;
        w[31:16]       = rem;
        w[StatBusyBit] = busy;
        w[StatDoneBit] = done;
        w[StatErrBit]  = err;
        return w;
    endfunction

endpackage

// File: rtl/flash_copy_dma_if.sv
// Bundle of the copy engine's CPU config, flash read and program-memory write signals.
interface flash_copy_dma_if;
    // CPU register port
    logic        cfg_wen;
    logic        cfg_ren;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    // Flash read port
    logic        flash_ren;
    logic [31:0] flash_addr;
    logic [31:0] flash_rdata;
    logic        flash_rvalid;
    // Program memory write port
    logic        cpu_pm_access;
    logic        pm_wen;
    logic [29:0] pm_addr;
    logic [31:0] pm_wdata;
    logic [3:0]  pm_byte_sel;
    // Status
    logic        cpu_hold;
    logic        busy;
    logic        done_irq;

    // Copy engine side
    modport master (
        input  cfg_wen, cfg_ren, cfg_addr, cfg_wdata,
        output cfg_rdata,
        output flash_ren, flash_addr,
        input  flash_rdata, flash_rvalid,
        input  cpu_pm_access,
        output pm_wen, pm_addr, pm_wdata, pm_byte_sel,
        output cpu_hold, busy, done_irq
    );

    // CPU / flash / memory side
    modport slave (
        output cfg_wen, cfg_ren, cfg_addr, cfg_wdata,
        input  cfg_rdata,
        input  flash_ren, flash_addr,
        output flash_rdata, flash_rvalid,
        output cpu_pm_access,
        input  pm_wen, pm_addr, pm_wdata, pm_byte_sel,
        input  cpu_hold, busy, done_irq
    );
endinterface

// File: rtl/flash_copy_dma_timeout_ctr.sv
// Flash response watchdog: cleared while a read is issued, counts while waiting,
// saturates and flags expiry once the count reaches TIMEOUT.
module flash_copy_dma_timeout_ctr #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] Limit = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // Wait-cycle counter, held at the limit so expiry stays asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != Limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == Limit);

endmodule

// File: rtl/flash_copy_dma.sv
// Flash-to-program-memory copy engine. Runs a boot image copy after reset while
// holding the CPU, then serves CPU-initiated copies via SRC/DST/LEN/CTRL registers.
module flash_copy_dma
    import flash_copy_dma_pkg::*;
#(
    parameter logic [31:0] BOOT_SRC      = 32'h0010_0000,
    parameter logic [31:0] BOOT_DST      = 32'h0000_0000,
    parameter int unsigned BOOT_LEN      = 1024,
    parameter bit          BOOT_ON_RESET = 1'b1,
    parameter int unsigned TIMEOUT       = 4095
) (
    input logic              clk,
    input logic              reset,
    flash_copy_dma_if.master dma_bus
);
    localparam logic [15:0] BootLen16 = 16'(BOOT_LEN);

    dma_state_e  r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_len;
    logic [15:0] r_rem;
    logic [31:0] r_data;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;
    logic        r_cpu_hold;
    logic        r_boot_pending;

    logic w_busy;
    logic w_ctrl_wr;
    logic w_start;
    logic w_abort;
    logic w_pm_wen;
    logic w_expired;

    assign w_busy    = (r_state == StReq) || (r_state == StWait) || (r_state == StWrite);
    assign w_ctrl_wr = dma_bus.cfg_wen && (dma_bus.cfg_addr == RegCtrl);
    // Abort wins over start when both bits are written together
    assign w_abort   = w_ctrl_wr && dma_bus.cfg_wdata[CtrlAbortBit];
    assign w_start   = w_ctrl_wr && dma_bus.cfg_wdata[CtrlStartBit] && !w_abort;
    // CPU owns program memory this cycle; an abort also suppresses the pending write
    assign w_pm_wen  = (r_state == StWrite) && !dma_bus.cpu_pm_access && !w_abort;

    flash_copy_dma_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (r_state == StReq),
        .i_en      (r_state == StWait),
        .o_expired (w_expired)
    );

    // Register file writes and the copy sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_src          <= '0;
            r_dst          <= '0;
            r_len          <= '0;
            r_rem          <= '0;
            r_data         <= '0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_cpu_hold     <= BOOT_ON_RESET;
            r_boot_pending <= BOOT_ON_RESET;
        end else begin
            if (dma_bus.cfg_wen && !w_busy) begin
                case (dma_bus.cfg_addr)
                    RegSrc:  r_src <= {dma_bus.cfg_wdata[31:2], 2'b00};
                    RegDst:  r_dst <= {dma_bus.cfg_wdata[31:2], 2'b00};
                    RegLen:  r_len <= dma_bus.cfg_wdata[15:0];
                    default: ;
                endcase
            end

            case (r_state)
                StIdle: begin
                    if (r_boot_pending) begin
                        r_boot_pending <= 1'b0;
                        r_src          <= {BOOT_SRC[31:2], 2'b00};
                        r_dst          <= {BOOT_DST[31:2], 2'b00};
                        r_len          <= BootLen16;
                        r_rem          <= BootLen16;
                        r_done         <= 1'b0;
                        r_err          <= 1'b0;
                        r_state        <= (BootLen16 == 16'd0) ? StDone : StReq;
                    end else if (w_start) begin
                        r_rem   <= r_len;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= (r_len == 16'd0) ? StDone : StReq;
                    end
                end
                StReq: r_state <= StWait;
                StWait: begin
                    if (dma_bus.flash_rvalid) begin
                        r_data  <= dma_bus.flash_rdata;
                        r_state <= StWrite;
                    end else if (w_expired) begin
                        r_state <= StErr;
                    end
                end
                StWrite: begin
                    if (w_pm_wen) begin
                        r_src   <= r_src + 32'd4;
                        r_dst   <= r_dst + 32'd4;
                        r_rem   <= r_rem - 16'd1;
                        r_state <= (r_rem == 16'd1) ? StDone : StReq;
                    end
                end
                StDone: begin
                    r_done     <= 1'b1;
                    r_cpu_hold <= 1'b0;
                    r_state    <= StIdle;
                end
                StErr: begin
                    r_err      <= 1'b1;
                    r_cpu_hold <= 1'b0;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase

            if (w_abort && w_busy) begin
                r_state <= StIdle;
            end
        end
    end

    // Registered CPU read data, updated only on a read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (dma_bus.cfg_ren) begin
            case (dma_bus.cfg_addr)
                RegSrc:  r_rdata <= r_src;
                RegDst:  r_rdata <= r_dst;
                RegLen:  r_rdata <= {16'd0, r_len};
                default: r_rdata <= status_word(w_busy, r_done, r_err, r_rem);
            endcase
        end
    end

    assign dma_bus.cfg_rdata   = r_rdata;
    assign dma_bus.flash_ren   = (r_state == StReq) || (r_state == StWait);
    assign dma_bus.flash_addr  = r_src;
    assign dma_bus.pm_wen      = w_pm_wen;
    assign dma_bus.pm_addr     = r_dst[31:2];
    assign dma_bus.pm_wdata    = r_data;
    assign dma_bus.pm_byte_sel = {4{w_pm_wen}};
    assign dma_bus.cpu_hold    = r_cpu_hold;
    assign dma_bus.busy        = w_busy;
    assign dma_bus.done_irq    = (r_state == StDone) || (r_state == StErr);

endmodule

// File: tb/tb_flash_copy_dma.sv
// Directed bench for flash_copy_dma with a latency-modelled flash and a write scoreboard.
module tb_flash_copy_dma;
    localparam logic [31:0] BootSrc  = 32'h0010_0000;
    localparam int          BootLen  = 4;
    localparam int          FlashLat = 3;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } pm_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    flash_copy_dma_if bus ();

    flash_copy_dma #(
        .BOOT_SRC      (BootSrc),
        .BOOT_DST      (32'h0000_0000),
        .BOOT_LEN      (BootLen),
        .BOOT_ON_RESET (1'b1),
        .TIMEOUT       (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dma_bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    pm_exp_t     pm_q[$];
    logic [31:0] fl_q[$];
    int          n_irq = 0;
    int          n_issue = 0;
    int          n_write = 0;
    int          n_rvalid = 0;
    int          last_gap = 0;
    int          gap_cnt = 0;
    bit          mute = 1'b0;
    int          stall_len = 0;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return 32'hA0 + ((a - BootSrc) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input bit with_pm);
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < len; i++) begin
            a = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            fl_q.push_back(a);
            if (with_pm) pm_q.push_back({d[31:2], fdata(a)});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_irq(input int target, input int max, input string tag);
        int i;
        i = 0;
        while (n_irq < target && i < max) begin
            tick(1);
            i++;
        end
        check(tag, n_irq, target);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.cfg_wen   = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(negedge clk);
        bus.cfg_wen = 1'b0;
        #2;
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.cfg_ren  = 1'b1;
        bus.cfg_addr = addr;
        @(negedge clk);
        bus.cfg_ren = 1'b0;
        #2;
        data = bus.cfg_rdata;
    endtask

    // Flash responder: latches a request, answers FlashLat cycles later, optionally
    // follows each answer with a burst of CPU program-memory accesses
    initial begin : flash_model
        int          cnt;
        bit          pend;
        bit          silent;
        int          stall;
        logic [31:0] addr;
        logic [31:0] exp;
        pend   = 1'b0;
        silent = 1'b0;
        cnt    = 0;
        stall  = 0;
        addr   = '0;
        bus.flash_rvalid  = 1'b0;
        bus.flash_rdata   = '0;
        bus.cpu_pm_access = 1'b0;
        forever begin
            @(negedge clk);
            bus.flash_rvalid = 1'b0;
            if (stall > 0) begin
                bus.cpu_pm_access = 1'b1;
                stall--;
            end else begin
                bus.cpu_pm_access = 1'b0;
            end
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                if (silent) begin
                    if (!bus.flash_ren) pend = 1'b0;
                end else begin
                    cnt--;
                    if (cnt == 0) begin
                        pend             = 1'b0;
                        bus.flash_rvalid = 1'b1;
                        bus.flash_rdata  = fdata(addr);
                        stall            = stall_len;
                        n_rvalid++;
                    end
                end
            end else if (bus.flash_ren) begin
                addr   = bus.flash_addr;
                pend   = 1'b1;
                silent = mute;
                cnt    = FlashLat;
                n_issue++;
                exp = (fl_q.size() != 0) ? fl_q.pop_front() : 32'hDEAD_BEEF;
                check("flash_addr", addr, exp);
            end
        end
    end

    // Output monitor: program-memory write scoreboard and interrupt counting
    initial begin : monitor
        pm_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.flash_rvalid) gap_cnt = 0;
            else gap_cnt++;
            if (bus.done_irq) n_irq++;
            if (bus.pm_wen) begin
                e = (pm_q.size() != 0) ? pm_q.pop_front() : {30'h3FFF_FFFF, 32'hDEAD_BEEF};
                check("pm_addr", {2'b00, bus.pm_addr}, {2'b00, e.addr});
                check("pm_wdata", bus.pm_wdata, e.data);
                check("pm_byte_sel", {28'd0, bus.pm_byte_sel}, 32'hF);
                check("pm_vs_cpu", {31'd0, bus.cpu_pm_access}, 32'd0);
                last_gap = gap_cnt;
                n_write++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"}, {31'd0, bus.cpu_hold}, 32'd1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_flash_ren"}, {31'd0, bus.flash_ren}, 32'd0);
        check({tag, "_pm_wen"}, {31'd0, bus.pm_wen}, 32'd0);
        check({tag, "_done_irq"}, {31'd0, bus.done_irq}, 32'd0);
        check({tag, "_cfg_rdata"}, bus.cfg_rdata, 32'd0);
        check({tag, "_byte_sel"}, {28'd0, bus.pm_byte_sel}, 32'd0);
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        int          iss0;
        int          w0;
        int          irq0;
        int          rv0;
        bus.cfg_wen   = 1'b0;
        bus.cfg_ren   = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;

        // 1: reset values, then boot copy
        tick(2);
        check_reset_outputs("rst");
        expect_copy(BootSrc, 32'h0, BootLen, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #2;
        tick(3);
        check("boot_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
        check("boot_busy", {31'd0, bus.busy}, 32'd1);
        wait_irq(1, 200, "boot_irq");
        tick(2);
        check("boot_hold_off", {31'd0, bus.cpu_hold}, 32'd0);
        check("boot_writes", n_write, BootLen);
        check("boot_pm_left", pm_q.size(), 0);
        check("boot_fl_left", fl_q.size(), 0);
        check("boot_irq_once", n_irq, 1);

        // 2: runtime copy
        cfg_write(2'd0, 32'h200);
        cfg_write(2'd1, 32'h40);
        cfg_write(2'd2, 32'd2);
        expect_copy(32'h200, 32'h40, 2, 1'b1);
        cfg_write(2'd3, 32'd1);
        wait_irq(2, 100, "copy_irq");
        tick(2);
        check("copy_pm_left", pm_q.size(), 0);
        check("copy_fl_left", fl_q.size(), 0);
        check("copy_gap", last_gap, 1);
        cfg_read(2'd3, rd);
        check("copy_status", rd, 32'h0000_0002);
        cfg_read(2'd0, rd);
        check("copy_src_rb", rd, 32'h208);
        cfg_read(2'd1, rd);
        check("copy_dst_rb", rd, 32'h48);

        // 3: CPU holds program memory for 5 cycles during WRITE
        w0 = n_write;
        stall_len = 5;
        cfg_write(2'd0, 32'h300);
        cfg_write(2'd1, 32'h80);
        cfg_write(2'd2, 32'd1);
        expect_copy(32'h300, 32'h80, 1, 1'b1);
        cfg_write(2'd3, 32'd1);
        wait_irq(3, 100, "stall_irq");
        tick(2);
        stall_len = 0;
        check("stall_gap", last_gap, 6);
        check("stall_writes", n_write - w0, 1);
        check("stall_pm_left", pm_q.size(), 0);

        // 4: flash never answers, timeout -> error
        mute = 1'b1;
        cfg_write(2'd0, 32'h400);
        cfg_write(2'd1, 32'h0);
        cfg_write(2'd2, 32'd3);
        expect_copy(32'h400, 32'h0, 1, 1'b0);
        cfg_write(2'd3, 32'd1);
        tick(3);
        check("tmo_busy_during", {31'd0, bus.busy}, 32'd1);
        wait_irq(4, 60, "tmo_irq");
        tick(2);
        mute = 1'b0;
        cfg_read(2'd3, rd);
        check("tmo_status", rd, 32'h0003_0004);
        check("tmo_busy", {31'd0, bus.busy}, 32'd0);
        check("tmo_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        check("tmo_irq_once", n_irq, 4);
        check("tmo_fl_left", fl_q.size(), 0);

        // 5: zero-length copy, start/write while busy, alignment and width masking
        iss0 = n_issue;
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd3, 32'd1);
        wait_irq(5, 5, "len0_irq");
        tick(2);
        check("len0_no_flash", n_issue, iss0);
        cfg_read(2'd3, rd);
        check("len0_status", rd, 32'h0000_0002);
        cfg_write(2'd0, 32'h500);
        cfg_write(2'd1, 32'h100);
        cfg_write(2'd2, 32'd2);
        expect_copy(32'h500, 32'h100, 2, 1'b1);
        cfg_write(2'd3, 32'd1);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        cfg_write(2'd3, 32'd1);
        cfg_write(2'd0, 32'h900);
        cfg_write(2'd2, 32'd7);
        wait_irq(6, 100, "busy_irq");
        tick(4);
        check("busy_irq_once", n_irq, 6);
        check("busy_idle", {31'd0, bus.busy}, 32'd0);
        check("busy_pm_left", pm_q.size(), 0);
        cfg_read(2'd0, rd);
        check("busy_src_kept", rd, 32'h508);
        cfg_read(2'd2, rd);
        check("busy_len_kept", rd, 32'd2);
        cfg_write(2'd0, 32'h603);
        cfg_read(2'd0, rd);
        check("src_align", rd, 32'h600);
        cfg_write(2'd2, 32'h0001_2345);
        cfg_read(2'd2, rd);
        check("len_mask", rd, 32'h2345);

        // 6: abort in WAIT with a late flash answer
        cfg_write(2'd0, 32'h700);
        cfg_write(2'd1, 32'h200);
        cfg_write(2'd2, 32'd2);
        fl_q.push_back(32'h700);
        iss0 = n_issue;
        w0   = n_write;
        irq0 = n_irq;
        rv0  = n_rvalid;
        cfg_write(2'd3, 32'd1);
        cfg_write(2'd3, 32'd2);
        tick(8);
        check("abort_issued", n_issue, iss0 + 1);
        check("abort_late_rvalid", n_rvalid, rv0 + 1);
        check("abort_no_write", n_write, w0);
        check("abort_no_irq", n_irq, irq0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_flash_ren", {31'd0, bus.flash_ren}, 32'd0);
        cfg_read(2'd3, rd);
        check("abort_status", rd, 32'h0002_0000);
        iss0 = n_issue;
        cfg_write(2'd3, 32'd3);
        tick(3);
        check("abort_wins_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_wins_flash", n_issue, iss0);

        // Reset mid-copy restarts the boot image
        cfg_write(2'd0, 32'h800);
        cfg_write(2'd1, 32'h300);
        cfg_write(2'd2, 32'd4);
        fl_q.push_back(32'h800);
        irq0 = n_irq;
        cfg_write(2'd3, 32'd1);
        #6;
        reset = 1'b1;
        tick(2);
        check_reset_outputs("mid_rst");
        check("mid_rst_fl_left", fl_q.size(), 0);
        expect_copy(BootSrc, 32'h0, BootLen, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #2;
        wait_irq(irq0 + 1, 200, "reboot_irq");
        tick(2);
        check("reboot_pm_left", pm_q.size(), 0);
        check("reboot_fl_left", fl_q.size(), 0);
        check("reboot_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        cfg_read(2'd0, rd);
        check("reboot_src_rb", rd, BootSrc + 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
